// File: rtl/tlb_unit_pkg.sv
// Shared TLB definitions: 78-bit CP0 entry layout, EntryLo subfields and the translation rule.
// Field offsets: VPN2 77:59, ASID 58:51, G 50, LO0 49:25, LO1 24:0.
package tlb_unit_pkg;

   localparam int unsigned EntryW    = 78;
   localparam int unsigned PBit      = 31;
   localparam logic [2:0]  CUncached = 3'd2;

   typedef struct packed {
      logic [19:0] pfn;
      logic [2:0]  c;
      logic        d;
      logic        v;
   } tlb_lo_t;

   typedef struct packed {
      logic [18:0] vpn2;
      logic [7:0]  asid;
      logic        g;
      tlb_lo_t     lo0;
      tlb_lo_t     lo1;
   } tlb_entry_t;

   typedef struct packed {
      logic [31:0] paddr;
      logic        refill;
      logic        invalid;
      logic        uncached;
      logic        modify;
   } lookup_res_t;

   // kseg0/kseg1 bypass the TLB; every exception forces paddr to zero.
   function automatic lookup_res_t translate(input logic [31:0] va, input logic hit,
                                             input tlb_lo_t lo, input logic store);
      lookup_res_t r;
      r = '0;
      if (va[31:30] == 2'b10) begin
         r.paddr    = {3'b000, va[28:0]};
         r.uncached = va[29];
      end else if (!hit) begin
         r.refill = 1'b1;
      end else if (!lo.v) begin
         r.invalid = 1'b1;
      end else if (store && !lo.d) begin
         r.modify = 1'b1;
      end else begin
         r.paddr    = {lo.pfn, va[11:0]};
         r.uncached = (lo.c == CUncached);
      end
      return r;
   endfunction

endpackage

// File: rtl/tlb_match.sv
// Combinational compare of one vpn2/asid against every TLB entry; lowest index wins.
module tlb_match
   import tlb_unit_pkg::*;
#(
   parameter int unsigned TLBNUM = 16,
   localparam int unsigned IW    = $clog2(TLBNUM)
) (
   input  tlb_entry_t [TLBNUM-1:0] entries,
   input  logic [18:0]             vpn2,
   input  logic [7:0]              asid,
   input  logic                    odd,
   output logic [TLBNUM-1:0]       hit_vec,
   output logic [IW-1:0]           idx,
   output tlb_lo_t                 lo
);

   always_comb begin
      hit_vec = '0;
      for (int i = 0; i < TLBNUM; i++) begin
         hit_vec[i] = (entries[i].vpn2 == vpn2) && (entries[i].g || (entries[i].asid == asid));
      end
   end

   // Scan downwards so the last assignment is the lowest matching index.
   always_comb begin
      idx = '0;
      lo  = '0;
      for (int i = TLBNUM - 1; i >= 0; i--) begin
         if (hit_vec[i]) begin
            idx = IW'(i);
            lo  = odd ? entries[i].lo1 : entries[i].lo0;
         end
      end
   end

endmodule

// File: rtl/tlb_unit.sv
// Fully associative joint TLB: CP0 tlbp/tlbr/tlbwi plus registered inst and data translation.
// Define TLB_MULTIHIT_CHK_EN to add the tlb_multihit output.
module tlb_unit
   import tlb_unit_pkg::*;
#(
   parameter int unsigned TLBNUM = 16,
   localparam int unsigned IW    = $clog2(TLBNUM)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [7:0]    cur_asid,
   input  logic          inst_req,
   input  logic [31:0]   inst_vaddr,
   output logic          inst_rvalid,
   output logic [31:0]   inst_paddr,
   output logic          inst_refill,
   output logic          inst_invalid,
   output logic          inst_uncached,
   input  logic          data_req,
   input  logic [31:0]   data_vaddr,
   input  logic          data_store,
   output logic          data_rvalid,
   output logic [31:0]   data_paddr,
   output logic          data_refill,
   output logic          data_invalid,
   output logic          data_uncached,
   output logic          data_modify,
   input  logic          tlbp_req,
   input  logic [31:0]   tlbp_entryhi,
   output logic          tlbp_wen,
   output logic [31:0]   tlbp_index,
   input  logic [IW-1:0] tlb_index,
   input  logic          tlbr_req,
   output logic          tlbr_wen,
   output logic [77:0]   tlbr_entry,
   input  logic          tlbwi_req,
   input  logic [77:0]   tlbwi_entry
`ifdef TLB_MULTIHIT_CHK_EN
   ,
   output logic          tlb_multihit
`endif
);

   tlb_entry_t [TLBNUM-1:0] tlb_q, tlb_d;
   logic                    inst_rvalid_q, data_rvalid_q, tlbp_wen_q, tlbr_wen_q;
   lookup_res_t             inst_res_q, inst_res_d, data_res_q, data_res_d;
   logic [31:0]             tlbp_index_q, tlbp_index_d;
   tlb_entry_t              tlbr_entry_q, tlbr_entry_d;

   logic [TLBNUM-1:0] inst_hv, data_hv, tlbp_hv;
   logic [IW-1:0]     inst_idx, data_idx, tlbp_idx;
   tlb_lo_t           inst_lo, data_lo, tlbp_lo;

   tlb_match #(.TLBNUM(TLBNUM)) u_inst_match (
      .entries (tlb_q),
      .vpn2    (inst_vaddr[31:13]),
      .asid    (cur_asid),
      .odd     (inst_vaddr[12]),
      .hit_vec (inst_hv),
      .idx     (inst_idx),
      .lo      (inst_lo)
   );

   tlb_match #(.TLBNUM(TLBNUM)) u_data_match (
      .entries (tlb_q),
      .vpn2    (data_vaddr[31:13]),
      .asid    (cur_asid),
      .odd     (data_vaddr[12]),
      .hit_vec (data_hv),
      .idx     (data_idx),
      .lo      (data_lo)
   );

   tlb_match #(.TLBNUM(TLBNUM)) u_tlbp_match (
      .entries (tlb_q),
      .vpn2    (tlbp_entryhi[31:13]),
      .asid    (tlbp_entryhi[7:0]),
      .odd     (1'b0),
      .hit_vec (tlbp_hv),
      .idx     (tlbp_idx),
      .lo      (tlbp_lo)
   );

   logic unused_ok;
   assign unused_ok = ^{inst_idx, data_idx, tlbp_lo, tlbp_entryhi[12:8]};

   // Lookups, probe and read all sample tlb_q, so a same-cycle tlbwi is seen one cycle later.
   always_comb begin
      tlb_d          = tlb_q;
      inst_res_d     = inst_res_q;
      data_res_d     = data_res_q;
      tlbp_index_d   = tlbp_index_q;
      tlbr_entry_d   = tlbr_entry_q;
      if (tlbwi_req) tlb_d[tlb_index] = tlbwi_entry;
      if (inst_req) inst_res_d = translate(inst_vaddr, |inst_hv, inst_lo, 1'b0);
      if (data_req) data_res_d = translate(data_vaddr, |data_hv, data_lo, data_store);
      if (tlbp_req) tlbp_index_d = {~(|tlbp_hv), {(PBit - IW){1'b0}}, tlbp_idx};
      if (tlbr_req) tlbr_entry_d = tlb_q[tlb_index];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tlb_q         <= '0;
         inst_rvalid_q <= 1'b0;
         data_rvalid_q <= 1'b0;
         tlbp_wen_q    <= 1'b0;
         tlbr_wen_q    <= 1'b0;
         inst_res_q    <= '0;
         data_res_q    <= '0;
         tlbp_index_q  <= '0;
         tlbr_entry_q  <= '0;
      end else begin
         tlb_q         <= tlb_d;
         inst_rvalid_q <= inst_req;
         data_rvalid_q <= data_req;
         tlbp_wen_q    <= tlbp_req;
         tlbr_wen_q    <= tlbr_req;
         inst_res_q    <= inst_res_d;
         data_res_q    <= data_res_d;
         tlbp_index_q  <= tlbp_index_d;
         tlbr_entry_q  <= tlbr_entry_d;
      end
   end

`ifdef TLB_MULTIHIT_CHK_EN
   logic multihit_q, multihit_d;

   always_comb begin
      multihit_d = (inst_req && ((inst_hv & (inst_hv - 1'b1)) != '0)) ||
                   (data_req && ((data_hv & (data_hv - 1'b1)) != '0)) ||
                   (tlbp_req && ((tlbp_hv & (tlbp_hv - 1'b1)) != '0));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) multihit_q <= 1'b0;
      else     multihit_q <= multihit_d;
   end

   assign tlb_multihit = multihit_q;
`endif

   assign inst_rvalid   = inst_rvalid_q;
   assign inst_paddr    = inst_res_q.paddr;
   assign inst_refill   = inst_res_q.refill;
   assign inst_invalid  = inst_res_q.invalid;
   assign inst_uncached = inst_res_q.uncached;
   assign data_rvalid   = data_rvalid_q;
   assign data_paddr    = data_res_q.paddr;
   assign data_refill   = data_res_q.refill;
   assign data_invalid  = data_res_q.invalid;
   assign data_uncached = data_res_q.uncached;
   assign data_modify   = data_res_q.modify;
   assign tlbp_wen      = tlbp_wen_q;
   assign tlbp_index    = tlbp_index_q;
   assign tlbr_wen      = tlbr_wen_q;
   assign tlbr_entry    = tlbr_entry_q;

endmodule

// File: tb/tb_tlb_unit.sv
// Self-checking bench for tlb_unit: directed cases then randomized traffic against an array model.
module tb_tlb_unit;

   localparam int unsigned TLBNUM = 16;
   localparam int unsigned IW     = $clog2(TLBNUM);

   logic          clk = 1'b0;
   logic          rst;
   logic [7:0]    cur_asid;
   logic          inst_req, inst_rvalid, inst_refill, inst_invalid, inst_uncached;
   logic [31:0]   inst_vaddr, inst_paddr;
   logic          data_req, data_store, data_rvalid, data_refill, data_invalid;
   logic          data_uncached, data_modify;
   logic [31:0]   data_vaddr, data_paddr;
   logic          tlbp_req, tlbp_wen;
   logic [31:0]   tlbp_entryhi, tlbp_index;
   logic [IW-1:0] tlb_index;
   logic          tlbr_req, tlbr_wen, tlbwi_req;
   logic [77:0]   tlbr_entry, tlbwi_entry;
`ifdef TLB_MULTIHIT_CHK_EN
   logic          tlb_multihit;
`endif

   tlb_unit #(.TLBNUM(TLBNUM)) dut (
      .clk           (clk),
      .rst           (rst),
      .cur_asid      (cur_asid),
      .inst_req      (inst_req),
      .inst_vaddr    (inst_vaddr),
      .inst_rvalid   (inst_rvalid),
      .inst_paddr    (inst_paddr),
      .inst_refill   (inst_refill),
      .inst_invalid  (inst_invalid),
      .inst_uncached (inst_uncached),
      .data_req      (data_req),
      .data_vaddr    (data_vaddr),
      .data_store    (data_store),
      .data_rvalid   (data_rvalid),
      .data_paddr    (data_paddr),
      .data_refill   (data_refill),
      .data_invalid  (data_invalid),
      .data_uncached (data_uncached),
      .data_modify   (data_modify),
      .tlbp_req      (tlbp_req),
      .tlbp_entryhi  (tlbp_entryhi),
      .tlbp_wen      (tlbp_wen),
      .tlbp_index    (tlbp_index),
      .tlb_index     (tlb_index),
      .tlbr_req      (tlbr_req),
      .tlbr_wen      (tlbr_wen),
      .tlbr_entry    (tlbr_entry),
      .tlbwi_req     (tlbwi_req),
      .tlbwi_entry   (tlbwi_entry)
`ifdef TLB_MULTIHIT_CHK_EN
      ,
      .tlb_multihit  (tlb_multihit)
`endif
   );

   always #5 clk = ~clk;

   logic [77:0] mem [TLBNUM];
   int n_checks = 0;
   int n_pass   = 0;

   logic        e_irv, e_iref, e_iinv, e_iunc;
   logic [31:0] e_ipa;
   logic        e_drv, e_dref, e_dinv, e_dunc, e_dmod;
   logic [31:0] e_dpa;
   logic        e_pwen, e_rwen, e_mh;
   logic [31:0] e_pidx;
   logic [77:0] e_rent;

   task automatic check(input string tag, input logic [77:0] got, input logic [77:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic [24:0] mk_lo(input logic [19:0] pfn, input logic [2:0] c,
                                         input logic d, input logic v);
      return {pfn, c, d, v};
   endfunction

   function automatic logic [77:0] mk_ent(input logic [18:0] vpn2, input logic [7:0] asid,
                                          input logic g, input logic [24:0] lo0,
                                          input logic [24:0] lo1);
      return {vpn2, asid, g, lo0, lo1};
   endfunction

   // Reference translation straight from the address-space rules.
   task automatic mdl_lookup(input logic [31:0] va, input logic [7:0] asid, input logic st,
                             output logic [31:0] pa, output logic rf, output logic inv,
                             output logic unc, output logic md, output logic mh);
      int hits;
      logic [24:0] lo;
      logic [77:0] e;
      hits = 0; lo = '0;
      pa = '0; rf = 0; inv = 0; unc = 0; md = 0;
      for (int i = 0; i < TLBNUM; i++) begin
         e = mem[i];
         if (e[77:59] == va[31:13] && (e[50] || e[58:51] == asid)) begin
            if (hits == 0) lo = va[12] ? e[24:0] : e[49:25];
            hits++;
         end
      end
      mh = (hits > 1);
      if (va[31:30] == 2'b10) begin
         pa = {3'b000, va[28:0]};
         unc = va[29];
      end else if (hits == 0) rf = 1;
      else if (!lo[0]) inv = 1;
      else if (st && !lo[1]) md = 1;
      else begin
         pa = {lo[24:5], va[11:0]};
         unc = (lo[4:2] == 3'd2);
      end
   endtask

   task automatic mdl_probe(input logic [31:0] hi, output logic [31:0] idx, output logic mh);
      int first, hits;
      logic [77:0] e;
      first = -1; hits = 0;
      for (int i = 0; i < TLBNUM; i++) begin
         e = mem[i];
         if (e[77:59] == hi[31:13] && (e[50] || e[58:51] == hi[7:0])) begin
            if (first < 0) first = i;
            hits++;
         end
      end
      mh = (hits > 1);
      idx = (first < 0) ? 32'h8000_0000 : 32'(first);
   endtask

   task automatic clear_model();
      for (int i = 0; i < TLBNUM; i++) mem[i] = '0;
      e_irv = 0; e_iref = 0; e_iinv = 0; e_iunc = 0; e_ipa = '0;
      e_drv = 0; e_dref = 0; e_dinv = 0; e_dunc = 0; e_dmod = 0; e_dpa = '0;
      e_pwen = 0; e_rwen = 0; e_mh = 0; e_pidx = '0; e_rent = '0;
   endtask

   task automatic idle();
      inst_req = 0; data_req = 0; data_store = 0; tlbp_req = 0; tlbr_req = 0; tlbwi_req = 0;
   endtask

   // One clock: predict from the pre-edge model, compare after the edge, then commit any write.
   task automatic cycle();
      logic mi, md, mp, dummy;
      mi = 0; md = 0; mp = 0;
      if (inst_req) mdl_lookup(inst_vaddr, cur_asid, 1'b0, e_ipa, e_iref, e_iinv, e_iunc,
                               dummy, mi);
      if (data_req) mdl_lookup(data_vaddr, cur_asid, data_store, e_dpa, e_dref, e_dinv,
                               e_dunc, e_dmod, md);
      if (tlbp_req) mdl_probe(tlbp_entryhi, e_pidx, mp);
      if (tlbr_req) e_rent = mem[tlb_index];
      e_irv = inst_req; e_drv = data_req; e_pwen = tlbp_req; e_rwen = tlbr_req;
      e_mh = (inst_req && mi) || (data_req && md) || (tlbp_req && mp);
      @(posedge clk); #1;
      check("inst_rvalid", inst_rvalid, e_irv);
      check("inst_paddr", inst_paddr, e_ipa);
      check("inst_flags", {inst_refill, inst_invalid, inst_uncached}, {e_iref, e_iinv, e_iunc});
      check("data_rvalid", data_rvalid, e_drv);
      check("data_paddr", data_paddr, e_dpa);
      check("data_flags", {data_refill, data_invalid, data_uncached, data_modify},
            {e_dref, e_dinv, e_dunc, e_dmod});
      check("tlbp_wen", tlbp_wen, e_pwen);
      check("tlbp_index", tlbp_index, e_pidx);
      check("tlbr_wen", tlbr_wen, e_rwen);
      check("tlbr_entry", tlbr_entry, e_rent);
`ifdef TLB_MULTIHIT_CHK_EN
      check("tlb_multihit", tlb_multihit, e_mh);
`endif
      if (tlbwi_req) mem[tlb_index] = tlbwi_entry;
   endtask

   function automatic logic [18:0] pick_vpn2();
      logic [18:0] v;
      case ($urandom_range(0, 3))
         0: v = 19'h00040;
         1: v = 19'h00041;
         2: v = 19'h7FFFF;
         default: v = 19'h00000;
      endcase
      return v;
   endfunction

   function automatic logic [31:0] pick_va();
      logic [31:0] r;
      r = $urandom;
      if ($urandom_range(0, 3) == 0) return r;
      return {pick_vpn2(), r[12:0]};
   endfunction

   logic [77:0] old_e, new_e;

   initial begin
      rst = 1'b1;
      cur_asid = '0; inst_vaddr = '0; data_vaddr = '0; tlbp_entryhi = '0;
      tlb_index = '0; tlbwi_entry = '0;
      idle();
      clear_model();
      repeat (2) @(posedge clk);
      #1;
      check("reset_rvalid", {inst_rvalid, data_rvalid, tlbp_wen, tlbr_wen}, 4'b0);
      check("reset_index", tlbp_index, 32'h0);
      rst = 1'b0;

      // Empty TLB: reset entries match vpn2=0/asid=0 but are invalid.
      inst_req = 1; inst_vaddr = 32'h0000_1000; cycle(); idle();
      check("tp_invalid", {inst_rvalid, inst_invalid, inst_refill}, 3'b110);
      inst_req = 1; inst_vaddr = 32'hA000_0100; cycle();
      check("tp_kseg1", {inst_paddr, inst_uncached}, {32'h0000_0100, 1'b1});
      inst_vaddr = 32'h8000_0100; cycle(); idle();
      check("tp_kseg0", {inst_paddr, inst_uncached, inst_refill}, {32'h0000_0100, 2'b00});

      old_e = mk_ent(19'h00040, 8'd5, 1'b0, mk_lo(20'h12345, 3'd3, 1'b1, 1'b1), '0);
      tlbwi_req = 1; tlb_index = 3; tlbwi_entry = old_e; cycle(); idle();
      cur_asid = 8'd5; data_req = 1; data_vaddr = 32'h0008_0ABC; cycle();
      check("tp_hit", {data_paddr, data_refill, data_invalid, data_modify},
            {32'h1234_5ABC, 3'b000});
      cur_asid = 8'd6; cycle(); idle();
      check("tp_asid_miss", {data_refill, data_paddr}, {1'b1, 32'h0});

      old_e = mk_ent(19'h00040, 8'd5, 1'b1, mk_lo(20'h12345, 3'd3, 1'b1, 1'b1),
                     mk_lo(20'h55555, 3'd2, 1'b0, 1'b1));
      tlbwi_req = 1; tlb_index = 3; tlbwi_entry = old_e; cycle(); idle();
      data_req = 1; data_vaddr = 32'h0008_0ABC; cycle();
      check("tp_global", {data_paddr, data_refill}, {32'h1234_5ABC, 1'b0});
      data_store = 1; data_vaddr = 32'h0008_1000; cycle(); idle();
      check("tp_modify", {data_modify, data_paddr}, {1'b1, 32'h0});

      tlbp_req = 1; tlbp_entryhi = 32'h0008_0005; cycle();
      check("tp_probe_hit", {tlbp_wen, tlbp_index}, {1'b1, 32'd3});
      tlbp_entryhi = 32'h7FFF_E005; cycle(); idle();
      check("tp_probe_miss", tlbp_index, 32'h8000_0000);

      new_e = mk_ent(19'h00041, 8'd7, 1'b0, mk_lo(20'hABCDE, 3'd2, 1'b1, 1'b1), '0);
      tlbwi_req = 1; tlbr_req = 1; tlb_index = 3; tlbwi_entry = new_e; cycle(); idle();
      check("tp_tlbr_old", tlbr_entry, old_e);
      tlbr_req = 1; cycle(); idle();
      check("tp_tlbr_new", tlbr_entry, new_e);

      // Reset landing between request and result drops the pending pulse.
      inst_req = 1; inst_vaddr = 32'h8000_0040;
      #2 rst = 1'b1;
      @(posedge clk); #1;
      check("rst_drop", {inst_rvalid, inst_paddr}, {1'b0, 32'h0});
      rst = 1'b0; idle(); clear_model();
      cycle();

      for (int n = 0; n < 400; n++) begin
         cur_asid     = 8'($urandom_range(0, 3));
         inst_req     = $urandom_range(0, 1);
         inst_vaddr   = pick_va();
         data_req     = $urandom_range(0, 1);
         data_vaddr   = pick_va();
         data_store   = $urandom_range(0, 1);
         tlbp_req     = $urandom_range(0, 2) == 0;
         tlbp_entryhi = {pick_vpn2(), 5'($urandom), 8'($urandom_range(0, 3))};
         tlb_index    = IW'($urandom_range(0, TLBNUM - 1));
         tlbr_req     = $urandom_range(0, 2) == 0;
         tlbwi_req    = $urandom_range(0, 1);
         tlbwi_entry  = mk_ent(pick_vpn2(), 8'($urandom_range(0, 3)), $urandom_range(0, 3) == 0,
                               25'($urandom), 25'($urandom));
         cycle();
      end
      idle();
      cycle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
